control_sequencer: RTL and testbench

//   Hardwired control unit for the Mini SRC datapath. Generates the T0..Tn

---
 rtl/mini_src_pkg.sv | 87 ++++++++
 rtl/ctrl_opclass_decode.sv | 51 +++++
 rtl/control_sequencer.sv | 155 +++++++++++++++
 tb/tb_control_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared Mini SRC definitions: opcodes, ALU codes, sequencer mode/step types and strobe bundle.
package mini_src_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 5;
  localparam int unsigned STEP_W = 3;

  typedef logic [OPC_W-1:0]  opcode_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam opcode_t OP_LD   = 5'd0;
  localparam opcode_t OP_LDI  = 5'd1;
  localparam opcode_t OP_ST   = 5'd2;
  localparam opcode_t OP_ADD  = 5'd3;
  localparam opcode_t OP_SUB  = 5'd4;
  localparam opcode_t OP_AND  = 5'd5;
  localparam opcode_t OP_OR   = 5'd6;
  localparam opcode_t OP_ROR  = 5'd7;
  localparam opcode_t OP_ROL  = 5'd8;
  localparam opcode_t OP_SHR  = 5'd9;
  localparam opcode_t OP_SHRA = 5'd10;
  localparam opcode_t OP_SHL  = 5'd11;
  localparam opcode_t OP_ADDI = 5'd12;
  localparam opcode_t OP_ANDI = 5'd13;
  localparam opcode_t OP_ORI  = 5'd14;
  localparam opcode_t OP_MUL  = 5'd15;
  localparam opcode_t OP_DIV  = 5'd16;
  localparam opcode_t OP_NEG  = 5'd17;
  localparam opcode_t OP_NOT  = 5'd18;
  localparam opcode_t OP_BR   = 5'd19;
  localparam opcode_t OP_JR   = 5'd20;
  localparam opcode_t OP_JAL  = 5'd21;
  localparam opcode_t OP_IN   = 5'd22;
  localparam opcode_t OP_OUT  = 5'd23;
  localparam opcode_t OP_MFHI = 5'd24;
  localparam opcode_t OP_MFLO = 5'd25;
  localparam opcode_t OP_NOP  = 5'd26;
  localparam opcode_t OP_HALT = 5'd27;

  // ALU codes share the opcode numbering of the register-form instructions
  localparam opcode_t ALU_ADD = OP_ADD;
  localparam opcode_t ALU_AND = OP_AND;
  localparam opcode_t ALU_OR  = OP_OR;

  localparam step_t T0 = 3'd0;
  localparam step_t T1 = 3'd1;
  localparam step_t T2 = 3'd2;
  localparam step_t T3 = 3'd3;
  localparam step_t T4 = 3'd4;
  localparam step_t T5 = 3'd5;
  localparam step_t T6 = 3'd6;
  localparam step_t T7 = 3'd7;

  typedef enum logic [1:0] {
    MODE_RST   = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_PAUSE = 2'd2,
    MODE_HALT  = 2'd3
  } mode_t;

  typedef struct packed {
    logic alu_rr;
    logic alu_un;
    logic alu_imm;
    logic ldi;
    logic ld;
    logic st;
    logic muldiv;
    logic br;
    logic jr;
    logic mfhi;
    logic mflo;
    logic inp;
    logic outp;
    logic halt;
    logic illegal;
  } opclass_t;

  // Field order matches the port concatenation in control_sequencer
  typedef struct packed {
    logic pcout, zhiout, zloout, mdrout, hiout, loout, inportout, cout, baout, rout;
    logic marin, mdrin, pcin, irin, yin, zin, hiin, loin, conin, outportin, rin;
    logic gra, grb, grc, incpc, read, write;
    opcode_t alu;
  } ctrl_t;

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Opcode -> one-hot instruction class, last step number and ALU code.
// CTRL_ILLEGAL_TRAP_EN: opcodes 111xx decode as illegal instead of nop.
module ctrl_opclass_decode
  import mini_src_pkg::*;
(
  input  opcode_t  opcode,
  output opclass_t opclass,
  output step_t    last_step,
  output opcode_t  alu_op
);

  always_comb begin
    opclass   = '0;
    last_step = T2;
    alu_op    = opcode;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        opclass.alu_rr = 1'b1;
        last_step      = T5;
      end
      OP_NEG, OP_NOT: begin
        opclass.alu_un = 1'b1;
        last_step      = T4;
      end
      OP_ADDI: begin opclass.alu_imm = 1'b1; last_step = T5; alu_op = ALU_ADD; end
      OP_ANDI: begin opclass.alu_imm = 1'b1; last_step = T5; alu_op = ALU_AND; end
      OP_ORI:  begin opclass.alu_imm = 1'b1; last_step = T5; alu_op = ALU_OR;  end
      OP_LDI:  begin opclass.ldi = 1'b1; last_step = T5; alu_op = ALU_ADD; end
      OP_LD:   begin opclass.ld  = 1'b1; last_step = T7; alu_op = ALU_ADD; end
      OP_ST:   begin opclass.st  = 1'b1; last_step = T7; alu_op = ALU_ADD; end
      OP_MUL, OP_DIV: begin
        opclass.muldiv = 1'b1;
        last_step      = T6;
      end
      OP_BR:   begin opclass.br = 1'b1; last_step = T6; alu_op = ALU_ADD; end
      OP_JR:   begin opclass.jr   = 1'b1; last_step = T3; end
      OP_MFHI: begin opclass.mfhi = 1'b1; last_step = T3; end
      OP_MFLO: begin opclass.mflo = 1'b1; last_step = T3; end
      OP_IN:   begin opclass.inp  = 1'b1; last_step = T3; end
      OP_OUT:  begin opclass.outp = 1'b1; last_step = T3; end
      OP_HALT: opclass.halt = 1'b1;
      OP_NOP, OP_JAL: begin end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        opclass.illegal = (opcode[OPC_W-1 -: 3] == 3'b111);
`endif
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: mode/step sequencer with strobes decoded from state and IR.
// CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the sequencer and raise Illegal.
module control_sequencer
  import mini_src_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] IR,
  input  logic              CON_FF,
  input  logic              Stop,
  output logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
  output logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, Rin,
  output logic Gra, Grb, Grc,
  output logic IncrementPC,
  output logic Read, Write,
  output logic [OPC_W-1:0]  ALUControl,
  output logic              Run,
  output logic              Illegal
);

  mode_t    mode, mode_nx;
  step_t    step, step_nx;
  logic     illegal_q, illegal_nx;
  opclass_t opclass;
  step_t    last_step;
  opcode_t  alu_op;
  ctrl_t    ctrl;
  logic     addr_calc;
  logic     unused_ir;

  assign unused_ir = ^IR[DATA_W-OPC_W-1:0];

  ctrl_opclass_decode u_decode (
    .opcode    (IR[DATA_W-1 -: OPC_W]),
    .opclass   (opclass),
    .last_step (last_step),
    .alu_op    (alu_op)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode      <= MODE_RST;
      step      <= T0;
      illegal_q <= 1'b0;
    end else begin
      mode      <= mode_nx;
      step      <= step_nx;
      illegal_q <= illegal_nx;
    end
  end

  // Mode/step advance; Stop and halt are only looked at on an instruction's last step
  always_comb begin
    mode_nx    = mode;
    step_nx    = step;
    illegal_nx = illegal_q;
    case (mode)
      MODE_RST: begin
        mode_nx = MODE_RUN;
        step_nx = T0;
      end
      MODE_RUN: begin
        if (step == last_step) begin
          step_nx = T0;
          if (opclass.halt || opclass.illegal) begin
            mode_nx = MODE_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_nx = illegal_q | opclass.illegal;
`endif
          end else if (Stop) begin
            mode_nx = MODE_PAUSE;
          end
        end else begin
          step_nx = step + step_t'(1);
        end
      end
      MODE_PAUSE: begin
        if (!Stop) begin
          mode_nx = MODE_RUN;
          step_nx = T0;
        end
      end
      default: begin end
    endcase
  end

  assign addr_calc = opclass.ldi | opclass.ld | opclass.st;

  // Strobe decode; every strobe is zero outside RUN
  always_comb begin
    ctrl = '0;
    if (mode == MODE_RUN) begin
      case (step)
        T0: begin ctrl.pcout = 1'b1; ctrl.marin = 1'b1; ctrl.incpc = 1'b1; ctrl.zin = 1'b1; end
        T1: begin ctrl.zloout = 1'b1; ctrl.pcin = 1'b1; ctrl.read = 1'b1; ctrl.mdrin = 1'b1; end
        T2: begin ctrl.mdrout = 1'b1; ctrl.irin = 1'b1; end
        T3: begin
          if (opclass.alu_rr || opclass.alu_imm) begin
            ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1;
          end
          if (addr_calc) begin ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.yin = 1'b1; end
          if (opclass.alu_un) begin
            ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_op; ctrl.zin = 1'b1;
          end
          if (opclass.muldiv) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.yin = 1'b1; end
          if (opclass.br) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.conin = 1'b1; end
          if (opclass.jr) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pcin = 1'b1; end
          if (opclass.mfhi) begin ctrl.hiout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          if (opclass.mflo) begin ctrl.loout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          if (opclass.inp) begin ctrl.inportout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          if (opclass.outp) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outportin = 1'b1; end
        end
        T4: begin
          if (opclass.alu_rr) begin
            ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_op; ctrl.zin = 1'b1;
          end
          if (opclass.alu_imm || addr_calc) begin
            ctrl.cout = 1'b1; ctrl.alu = alu_op; ctrl.zin = 1'b1;
          end
          if (opclass.alu_un) begin ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          if (opclass.muldiv) begin
            ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.alu = alu_op; ctrl.zin = 1'b1;
          end
          if (opclass.br) begin ctrl.pcout = 1'b1; ctrl.yin = 1'b1; end
        end
        T5: begin
          if (opclass.alu_rr || opclass.alu_imm || opclass.ldi) begin
            ctrl.zloout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
          end
          if (opclass.ld || opclass.st) begin ctrl.zloout = 1'b1; ctrl.marin = 1'b1; end
          if (opclass.muldiv) begin ctrl.zloout = 1'b1; ctrl.loin = 1'b1; end
          if (opclass.br) begin ctrl.cout = 1'b1; ctrl.alu = alu_op; ctrl.zin = 1'b1; end
        end
        T6: begin
          if (opclass.ld) begin ctrl.read = 1'b1; ctrl.mdrin = 1'b1; end
          if (opclass.st) begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdrin = 1'b1; end
          if (opclass.muldiv) begin ctrl.zhiout = 1'b1; ctrl.hiin = 1'b1; end
          if (opclass.br) begin ctrl.zloout = 1'b1; ctrl.pcin = CON_FF; end
        end
        T7: begin
          if (opclass.ld) begin ctrl.mdrout = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
          if (opclass.st) ctrl.write = 1'b1;
        end
      endcase
    end
  end

  assign {PCout, ZHIout, ZLOout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout,
          MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, Rin,
          Gra, Grb, Grc, IncrementPC, Read, Write, ALUControl} = ctrl;

  assign Run     = (mode == MODE_RUN);
  assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected strobe words from a step-table model.
module tb_control_sequencer;
  import mini_src_pkg::*;

  typedef logic [33:0] word_t;
  typedef struct packed { word_t w; logic [4:0] op; logic [3:0] t; } exp_t;

  localparam word_t PCOUT = word_t'(1) << 0,  ZHIOUT = word_t'(1) << 1,  ZLOOUT = word_t'(1) << 2;
  localparam word_t MDROUT = word_t'(1) << 3, HIOUT = word_t'(1) << 4,   LOOUT = word_t'(1) << 5;
  localparam word_t INPOUT = word_t'(1) << 6, COUT = word_t'(1) << 7,    BAOUT = word_t'(1) << 8;
  localparam word_t ROUT = word_t'(1) << 9,   MARIN = word_t'(1) << 10,  MDRIN = word_t'(1) << 11;
  localparam word_t PCIN = word_t'(1) << 12,  IRIN = word_t'(1) << 13,   YIN = word_t'(1) << 14;
  localparam word_t ZIN = word_t'(1) << 15,   HIIN = word_t'(1) << 16,   LOIN = word_t'(1) << 17;
  localparam word_t CONIN = word_t'(1) << 18, OUTPIN = word_t'(1) << 19, RIN = word_t'(1) << 20;
  localparam word_t GRA = word_t'(1) << 21,   GRB = word_t'(1) << 22,    GRC = word_t'(1) << 23;
  localparam word_t INCPC = word_t'(1) << 24, READ = word_t'(1) << 25,   WRITE = word_t'(1) << 26;
  localparam word_t RUNB = word_t'(1) << 32,  ILLB = word_t'(1) << 33;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock, Reset_n, CON_FF, Stop;
  logic [31:0] IR;
  logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin, Rin;
  logic Gra, Grb, Grc, IncrementPC, Read, Write, Run, Illegal;
  logic [4:0] ALUControl;

  control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .MDRin(MDRin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncrementPC(IncrementPC), .Read(Read),
    .Write(Write), .ALUControl(ALUControl), .Run(Run), .Illegal(Illegal)
  );

  word_t obs;
  assign obs = {Illegal, Run, ALUControl, Write, Read, IncrementPC, Grc, Grb, Gra, Rin,
                OutPortin, CONin, LOin, HIin, Zin, Yin, IRin, PCin, MDRin, MARin, Rout,
                BAout, Cout, InPortout, LOout, HIout, MDRout, ZLOout, ZHIout, PCout};

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   armed = 1'b0;
  bit   trapped = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  // Monitor: one expected word per cycle, compared mid-cycle
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (armed) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL ctrl_underflow: got=%h required=<queued word>", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs === e.w) n_pass++;
          else $display("FAIL ctrl_word op=%0d t=%0d got=%h required=%h", e.op, e.t, obs, e.w);
        end
      end
    end
  end

  function automatic word_t alu(input logic [4:0] code);
    return word_t'(code) << 27;
  endfunction

  task automatic push(input word_t w, input logic [4:0] op, input int t);
    exp_t e;
    e.w = w; e.op = op; e.t = 4'(t);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; trapped = 1'b0;
    push('0, 5'd31, 15); cyc(1);
    Reset_n = 1'b1;
    push('0, 5'd31, 15); cyc(1);
  endtask

  // Runs one instruction from T0; stop_at/abort_at < 0 disables that behaviour
  task automatic run_instr(input logic [31:0] ir, input bit con, input int stop_at,
                           input int pause_len, input int abort_at);
    word_t seq[$];
    logic [4:0] op;
    logic [4:0] ic;
    bit halting;
    op = ir[31:27];
    IR = ir; CON_FF = con;
    seq.push_back(PCOUT | MARIN | INCPC | ZIN);
    seq.push_back(ZLOOUT | PCIN | READ | MDRIN);
    seq.push_back(MDROUT | IRIN);
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL}) begin
      seq.push_back(GRB | ROUT | YIN);
      seq.push_back(GRC | ROUT | alu(op) | ZIN);
      seq.push_back(ZLOOUT | GRA | RIN);
    end else if (op inside {OP_NEG, OP_NOT}) begin
      seq.push_back(GRB | ROUT | alu(op) | ZIN);
      seq.push_back(ZLOOUT | GRA | RIN);
    end else if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
      ic = (op == OP_ADDI) ? 5'b00011 : (op == OP_ANDI) ? OP_AND : OP_OR;
      seq.push_back(GRB | ROUT | YIN);
      seq.push_back(COUT | alu(ic) | ZIN);
      seq.push_back(ZLOOUT | GRA | RIN);
    end else if (op inside {OP_LDI, OP_LD, OP_ST}) begin
      seq.push_back(GRB | BAOUT | YIN);
      seq.push_back(COUT | alu(5'b00011) | ZIN);
      if (op == OP_LDI) seq.push_back(ZLOOUT | GRA | RIN);
      else begin
        seq.push_back(ZLOOUT | MARIN);
        if (op == OP_LD) begin
          seq.push_back(READ | MDRIN);
          seq.push_back(MDROUT | GRA | RIN);
        end else begin
          seq.push_back(GRA | ROUT | MDRIN);
          seq.push_back(WRITE);
        end
      end
    end else if (op inside {OP_MUL, OP_DIV}) begin
      seq.push_back(GRA | ROUT | YIN);
      seq.push_back(GRB | ROUT | alu(op) | ZIN);
      seq.push_back(ZLOOUT | LOIN);
      seq.push_back(ZHIOUT | HIIN);
    end else if (op == OP_BR) begin
      seq.push_back(GRA | ROUT | CONIN);
      seq.push_back(PCOUT | YIN);
      seq.push_back(COUT | alu(5'b00011) | ZIN);
      seq.push_back(ZLOOUT | (con ? PCIN : '0));
    end else if (op == OP_JR)   seq.push_back(GRA | ROUT | PCIN);
    else if (op == OP_MFHI)     seq.push_back(HIOUT | GRA | RIN);
    else if (op == OP_MFLO)     seq.push_back(LOOUT | GRA | RIN);
    else if (op == OP_IN)       seq.push_back(INPOUT | GRA | RIN);
    else if (op == OP_OUT)      seq.push_back(GRA | ROUT | OUTPIN);
    halting = (op == OP_HALT) || (TRAP && op[4:2] == 3'b111);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (i == stop_at) Stop = 1'b1;
      push(seq[i] | RUNB, op, i);
      cyc(1);
    end
    if (halting) begin
      trapped = (op != OP_HALT);
    end else if (Stop) begin
      for (int k = 0; k < pause_len; k++) begin push('0, op, 8); cyc(1); end
      Stop = 1'b0;
      push('0, op, 8); cyc(1);
    end
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) begin push(trapped ? ILLB : '0, OP_HALT, 9); cyc(1); end
  endtask

  logic [4:0] ops[$];

  initial begin
    logic [4:0] op;
    int sa;
    ops = '{OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
            OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT,
            OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP};
    Reset_n = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = '0;
    cyc(1);
    armed = 1'b1;
    do_reset();
    run_instr(32'h28918000, 1'b0, -1, 0, -1);
    run_instr(32'h00800055, 1'b0, -1, 0, -1);
    run_instr({5'b10011, 27'($urandom)}, 1'b0, -1, 0, -1);
    run_instr({5'b10011, 27'($urandom)}, 1'b1, -1, 0, -1);
    run_instr(32'h18000000, 1'b0, 4, 3, -1);
    for (int n = 0; n < 150; n++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), sa,
                int'($urandom_range(0, 3)), -1);
    end
    run_instr(32'h00800055, 1'b0, -1, 0, 6);
    run_instr(32'h28918000, 1'b0, -1, 0, -1);
    run_instr(32'hD8000000, 1'b0, -1, 0, -1);
    hold_halt(100);
    do_reset();
    run_instr(32'h18000000, 1'b0, -1, 0, -1);
    run_instr(32'hF8000000, 1'b0, -1, 0, -1);
    if (TRAP) begin
      hold_halt(20);
      do_reset();
    end
    run_instr(32'h20000000, 1'b0, -1, 0, -1);
    armed = 1'b0;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: left=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
